rr_merge: RTL and testbench
===========================

RR_MERGE -- requirements
Module: rr_merge

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of input channels (range 2..16).
REQ-002 Parameter DATA_TYPE, default 32, data width per channel in bits.
REQ-003 Parameter INDEX_TYPE, default 2, width of index output; SHALL equal ceil(log2(NUM_INPUTS)).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ins  input  NUM_INPUTS*DATA_TYPE  packed input data; channel i at bits [i*DATA_TYPE +: DATA_TYPE].
REQ-007 ins_valid  input  NUM_INPUTS  per-channel valid.
REQ-008 ins_ready  output  NUM_INPUTS  per-channel ready.
REQ-009 outs  output  DATA_TYPE  merged data.
REQ-010 index  output  INDEX_TYPE  number of the input channel that supplied outs.
REQ-011 outs_valid  output  1  outs/index valid.
REQ-012 outs_ready  input  1  downstream ready.

Function
REQ-013 Block SHALL merge NUM_INPUTS elastic channels into one output channel through a single output register slot; a transfer occurs on any channel when valid and ready are both high at a rising edge.
REQ-014 Slot load enable: load = ~outs_valid | outs_ready; the slot SHALL accept a new token in the same cycle the held token leaves (full throughput, one token per cycle).
REQ-015 Latency: token accepted at edge N SHALL appear on outs/index with outs_valid high in the cycle after edge N.
REQ-016 Arbitration SHALL be round-robin: priority pointer P (INDEX_TYPE bits) names the highest-priority channel; search order P, P+1, ..., NUM_INPUTS-1, 0, ..., P-1 (wrap modulo NUM_INPUTS).
REQ-017 Grant SHALL be one-hot or zero; granted channel g = first channel in search order with ins_valid high.
REQ-018 ins_ready[i] SHALL be high iff i == g and load is high; all other ins_ready low; no combinational path from ins_valid[j] to ins_ready[i] other than through the arbitration.
REQ-019 On a transfer from channel g, P SHALL update to (g+1) mod NUM_INPUTS; with g = NUM_INPUTS-1, P wraps to 0.
REQ-020 When no ins_valid is high, or load is low, P SHALL remain unchanged and the slot SHALL not load.
REQ-021 A sole active requester SHALL be granted every cycle load is high (no bubbles imposed by fairness).
REQ-022 With all inputs continuously valid and outs_ready high, grants SHALL cycle 0,1,...,NUM_INPUTS-1 and repeat; starvation bound: any valid input granted within NUM_INPUTS transfers.
REQ-023 While outs_valid high and outs_ready low, outs and index SHALL remain stable and all ins_ready SHALL be low.
REQ-024 On load, slot SHALL capture data of channel g into outs and g into index; outs_valid set high.
REQ-025 If outs_ready high, outs_valid high and no input valid, outs_valid SHALL go low next cycle.
REQ-026 Block SHALL not require ins_valid to be persistent; arbitration is recomputed every cycle.

Reset
REQ-027 While rst high at an edge: outs_valid <= 0, outs <= 0, index <= 0, P <= 0.
REQ-028 ins_ready SHALL be low in any cycle where rst is high.
REQ-029 Reset mid-operation SHALL discard the held token; first grant after reset starts at channel 0.

Structure
REQ-030 Round-robin search and pointer register SHALL be a sub-module rr_arbiter (ports: clk, rst, req, enable, grant one-hot, grant_index); rr_merge holds the output slot and data mux.
REQ-031 The ceil-log2 helper used to check INDEX_TYPE SHALL reside in the shared package; no block-local typedefs.

Verification
REQ-032 Reset: rst high 2 cycles with all ins_valid=1111 -> ins_ready=0000, outs_valid=0 throughout; first grant after release to channel 0.
REQ-033 Fairness: NUM_INPUTS=4, ins_valid=1111 constant, ins[i]=0x10+i, outs_ready=1 -> outs sequence 0x10,0x11,0x12,0x13,0x10 with index 0,1,2,3,0, one per cycle.
REQ-034 Backpressure: token 0xAA from ch2 held, outs_ready=0 for 5 cycles -> outs=0xAA, index=2 stable, ins_ready=0000; on outs_ready=1 next grant is ch3 if valid.
REQ-035 Sole requester: only ch1 valid with values 1..8, outs_ready=1 -> 8 consecutive outputs 1..8, index=1, no bubbles.
REQ-036 Wrap/skip: P=3, ins_valid=0101 -> grant ch0, then ch2, then ch0.
REQ-037 Reset mid-stream: rst pulsed while outs_valid=1 -> outs_valid=0 next cycle, held token never emitted, P=0.

Source files
------------

// File: rtl/rr_merge_pkg.sv
// Shared helpers for the round-robin merge block.
package rr_merge_pkg;

  // Ceiling log2, used to validate index widths at elaboration.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((32'd1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            d;
  int            best_d;

  // Pick the requester with the smallest circular distance from the pointer.
  always_comb begin
    best_d      = N;
    d           = 0;
    grant_index = '0;
    for (int c = 0; c < N; c++) begin
      d = (c >= int'(ptr_q)) ? c - int'(ptr_q) : c + N - int'(ptr_q);
      if (req[c] && d < best_d) begin
        best_d      = d;
        grant_index = IW'(c);
      end
    end
    found = (best_d != N);
  end

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    if (found && enable) begin
      grant[grant_index] = 1'b1;
      ptr_d = (grant_index == IW'(N - 1)) ? '0 : grant_index + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_merge.sv
// Merges NUM_INPUTS elastic channels into one registered output, round-robin fair.
module rr_merge
  import rr_merge_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_TYPE  = 32,
  parameter int INDEX_TYPE = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_TYPE-1:0]  ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_TYPE-1:0]             outs,
  output logic [INDEX_TYPE-1:0]            index,
  output logic                             outs_valid,
  input  logic                             outs_ready
);

  if (INDEX_TYPE != int'(clog2_f(NUM_INPUTS))) begin : g_bad_index_type
    $error("rr_merge: INDEX_TYPE must equal ceil(log2(NUM_INPUTS))");
  end

  logic [NUM_INPUTS-1:0][DATA_TYPE-1:0] ins_arr;
  logic [DATA_TYPE-1:0]                 outs_q, outs_d;
  logic [INDEX_TYPE-1:0]                index_q, index_d;
  logic                                 outs_valid_q, outs_valid_d;
  logic                                 load;
  logic [NUM_INPUTS-1:0]                grant;
  logic [INDEX_TYPE-1:0]                gidx;

  assign ins_arr = ins;

  // Slot frees when empty or draining; reset blocks all handshakes.
  assign load = (~outs_valid_q | outs_ready) & ~rst;

  rr_arbiter #(.N(NUM_INPUTS), .IW(INDEX_TYPE)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (ins_valid),
    .enable      (load),
    .grant       (grant),
    .grant_index (gidx)
  );

  assign ins_ready = grant;

  always_comb begin
    outs_d       = outs_q;
    index_d      = index_q;
    outs_valid_d = outs_valid_q;
    if (load) begin
      outs_valid_d = |grant;
      if (|grant) begin
        outs_d  = ins_arr[gidx];
        index_d = gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q       <= '0;
      index_q      <= '0;
      outs_valid_q <= 1'b0;
    end else begin
      outs_q       <= outs_d;
      index_q      <= index_d;
      outs_valid_q <= outs_valid_d;
    end
  end

  assign outs       = outs_q;
  assign index      = index_q;
  assign outs_valid = outs_valid_q;

endmodule

// File: tb/tb_rr_merge.sv
// Bench for rr_merge: per-cycle model comparison plus directed literal checks.
module tb_rr_merge;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][DW-1:0] ins;
  logic [N-1:0]         ins_valid;
  logic [N-1:0]         ins_ready;
  logic [DW-1:0]        outs;
  logic [IW-1:0]        index;
  logic                 outs_valid;
  logic                 outs_ready;

  rr_merge #(.NUM_INPUTS(N), .DATA_TYPE(DW), .INDEX_TYPE(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .index      (index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one slot, a priority pointer, transfers per the handshake rules.
  int           m_p = 0;
  bit           m_valid = 0;
  logic [31:0]  m_data = 0;
  int           m_idx = 0;
  int           cyc = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit m_load();
    return (!m_valid || outs_ready) && !rst;
  endfunction

  typedef struct { int c; int idx; logic [31:0] data; } ev_t;
  ev_t log_q[$];

  always @(posedge clk) begin
    int g;
    cyc++;
    if (!rst && outs_valid && outs_ready) log_q.push_back('{cyc, int'(index), outs});
    g = pick(ins_valid, m_p);
    if (rst) begin
      m_valid = 0; m_data = 0; m_idx = 0; m_p = 0;
    end else if (m_load()) begin
      if (g >= 0) begin
        m_valid = 1; m_data = ins[g]; m_idx = g; m_p = (g + 1) % N;
      end else m_valid = 0;
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      logic [N-1:0] exp_rdy;
      int g;
      @(negedge clk);
      exp_rdy = '0;
      g = pick(ins_valid, m_p);
      if (m_load() && g >= 0) exp_rdy[g] = 1'b1;
      chk("model_outs_valid", 32'(outs_valid), 32'(m_valid));
      chk("model_outs", outs, m_data);
      chk("model_index", 32'(index), 32'(m_idx));
      chk("model_ins_ready", 32'(ins_ready), 32'(exp_rdy));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; ins_valid = '0; step(); step(); rst = 0;
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N; i++) ins[i] = 32'h10 + i;
  endtask

  initial begin
    int exp_d[5];
    int exp_i[5];
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10};
    exp_i = '{0, 1, 2, 3, 0};
    rst = 1; outs_ready = 1; ins_valid = 4'b1111; set_default_data();

    // Reset held two cycles with all inputs valid.
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_ins_ready", 32'(ins_ready), 32'h0);
      chk("rst_outs_valid", 32'(outs_valid), 32'h0);
    end
    rst = 0; #1;
    chk("first_grant_ch0", 32'(ins_ready), 32'h1);

    // Fairness: all valid, rotation 0,1,2,3,0 one per cycle.
    log_q.delete();
    for (int k = 0; k < 6; k++) step();
    if (log_q.size() < 5) chk("fair_count", 32'(log_q.size()), 32'd5);
    else for (int k = 0; k < 5; k++) begin
      chk("fair_data", log_q[k].data, 32'(exp_d[k]));
      chk("fair_index", 32'(log_q[k].idx), 32'(exp_i[k]));
      if (k > 0) chk("fair_no_bubble", 32'(log_q[k].c - log_q[k-1].c), 32'd1);
    end

    // Backpressure: hold 0xAA from ch2 for five cycles.
    do_reset();
    ins[2] = 32'hAA; ins_valid = 4'b0100; outs_ready = 0;
    step();
    ins_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_outs", outs, 32'hAA);
      chk("bp_index", 32'(index), 32'd2);
      chk("bp_ins_ready", 32'(ins_ready), 32'h0);
      step();
    end
    outs_ready = 1; #1;
    chk("bp_next_grant_ch3", 32'(ins_ready), 32'b1000);
    step();
    chk("bp_after_outs", outs, 32'h13);
    chk("bp_after_index", 32'(index), 32'd3);

    // Sole requester on ch1, values 1..8 back to back.
    set_default_data();
    do_reset();
    log_q.delete();
    ins_valid = 4'b0010; outs_ready = 1;
    for (int v = 1; v <= 8; v++) begin ins[1] = 32'(v); step(); end
    ins_valid = '0; step(); step();
    chk("sole_count", 32'(log_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      chk("sole_data", log_q[k].data, 32'(k + 1));
      chk("sole_index", 32'(log_q[k].idx), 32'd1);
      if (k > 0) chk("sole_no_bubble", 32'(log_q[k].c - log_q[k-1].c), 32'd1);
    end

    // Wrap/skip: pointer at 3 with channels 0 and 2 requesting.
    set_default_data();
    do_reset();
    log_q.delete();
    ins_valid = 4'b0100; step();
    ins_valid = 4'b0101; step(); step(); step();
    ins_valid = '0; step(); step();
    chk("wrap_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 4) begin
      chk("wrap_idx0", 32'(log_q[0].idx), 32'd2);
      chk("wrap_idx1", 32'(log_q[1].idx), 32'd0);
      chk("wrap_idx2", 32'(log_q[2].idx), 32'd2);
      chk("wrap_idx3", 32'(log_q[3].idx), 32'd0);
    end

    // Reset mid-stream discards the held token.
    do_reset();
    log_q.delete();
    ins[3] = 32'h55; ins_valid = 4'b1000; outs_ready = 0;
    step();
    chk("mid_held_valid", 32'(outs_valid), 32'h1);
    rst = 1; ins_valid = '0; outs_ready = 1;
    step();
    chk("mid_rst_outs_valid", 32'(outs_valid), 32'h0);
    rst = 0; step();
    ins_valid = 4'b1111; ins[3] = 32'h13; #1;
    chk("mid_first_grant_ch0", 32'(ins_ready), 32'h1);
    step(); step();
    ins_valid = '0; step();
    foreach (log_q[k]) chk("mid_no_stale", 32'(log_q[k].data == 32'h55), 32'h0);
    if (log_q.size() > 0) chk("mid_first_idx", 32'(log_q[0].idx), 32'd0);
    else chk("mid_emit_count", 32'(log_q.size()), 32'd1);

    @(posedge clk); @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
